aes128_enc_unrolled: RTL and testbench
======================================

# aes128_enc_unrolled

Parametrised AES-128 encryption engine with a configurable number of rounds per clock (UNROLL) and an output hold/acknowledge handshake. It iterates over 10/UNROLL cycles with an on-the-fly key schedule and sits between the host data interface and the result consumer. It replaces the fixed one-round-per-cycle core where throughput or area must be traded at build time.

## Interface
- UNROLL, default 1: rounds computed per clock. Legal values are 1, 2, 5 and 10; any other value is an elaboration error.
- NITER, derived, 10/UNROLL: iteration cycles per block.

Ports (clock and reset first):
- CLK  in  1  system clock; the block uses one clock.
- RST  in  1  reset; synchronous and active-high.
- EN  in  1  global enable; when low, all state freezes.
- Kin  in  128  cipher key.
- Krdy  in  1  key-load strobe.
- Kvld  out  1  one-cycle pulse acknowledging a key load.
- Din  in  128  plaintext.
- Drdy  in  1  data-load strobe.
- Dout  out  128  ciphertext; held stable while Dvld is high.
- Dvld  out  1  result valid; held until acknowledged.
- Dack  in  1  consumer acknowledge of Dout.
- BSY  out  1  high in RUN and DONE.
- RKout  out  128  last round key (present only with AES_RKEY_OUT_EN).

## Operation
- All flops reset synchronously. On RST high at a rising edge:
  - state is IDLE.
  - Dout, key register and round-key register are 0.
  - Kvld, Dvld and BSY are 0.
  - round counter is 0.
- RST takes effect regardless of EN. A reset mid-RUN or in DONE aborts the block, and no Dvld follows.
- When EN is low, nothing updates, including Kvld and the pulse counter. Outputs hold.
- State machine: IDLE → RUN → DONE.
- IDLE:
  - Krdy: key ← Kin, Kvld = 1 for one cycle. Krdy wins over a simultaneous Drdy, which is dropped.
  - Drdy with no Krdy: dat ← Din ^ key, rkey ← key, cnt ← 0, then go to RUN.
- RUN:
  - Each enabled cycle applies UNROLL chained round units to dat/rkey, then cnt++.
  - Unit i in iteration cnt performs round r = cnt·UNROLL + i + 1 using RCON[r].
  - Round 10 omits MixColumns.
  - When cnt = NITER−1, the state moves to DONE and Dout ← result.
- DONE: Dvld = 1 and Dout is held.
  - Dack returns the block to IDLE.
  - Dack together with Drdy in the same cycle accepts the new block immediately and goes to RUN (back-to-back). Dvld falls in that case.
- Krdy outside IDLE is ignored; Kvld stays 0. Drdy outside IDLE is ignored, except for the back-to-back case above.
- Dack outside DONE is ignored.
- Key persists across blocks until the next accepted Krdy.

## Timing
- Latency: Dvld is high in the cycle after the NITER-th iteration edge. For UNROLL=1 that is 10 edges after the edge sampling Drdy; for UNROLL=10 it is 1 edge.
- Throughput with Dack tied high and Drdy held high: one block per NITER+1 cycles, because the DONE cycle overlaps the next load.
- Kvld rises on the edge after Krdy is sampled and falls one edge later.
- BSY rises on the edge after Drdy is accepted. It stays high until the Dack edge, or stays high continuously for back-to-back operation.
- The critical path scales with UNROLL: one S-box plus MixColumns plus key step per unit.

## Configuration
- AES_RKEY_OUT_EN defined:
  - RKout port exists and holds the round-10 key of the last completed block.
  - RKout is updated together with Dout and reset to 0.
  - It is used to seed a decryptor.
- Not defined: the port and its 128-bit register are absent. All other behaviour is identical.

## Structure
- Package aes_pkg holds:
  - NR = 10.
  - RCON[1:10] constant table.
  - state enum {IDLE, RUN, DONE}.
  - xtime and affine functions.
  - UNROLL legality check function.
- Sub-module aes_round_unit (combinational) performs one round:
  - composite-field SubBytes, ShiftRows, MixColumns with a bypass input for the last round, AddRoundKey;
  - the matching key-schedule step with rcon input.
- aes_round_unit is instantiated UNROLL times in a generate chain. The top holds the FSM, counter and registers.

## Test plan
- UNROLL=1, key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, Dack high → Dout 3925841d02dc09fbdc118597196a0b32, Dvld 10 edges after Drdy. With the macro, RKout = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Each of UNROLL=2, 5 and 10, key 000102…0f, pt 00112233445566778899aabbccddeeff → 69c4e0d86a7b0430d8cdb78070b4c55a, latency 5, 2 and 1 edges respectively.
- Dack held low 7 cycles after Dvld → Dout and Dvld stable. A Drdy pulse in that window is ignored. Dack+Drdy together → next block starts with no idle cycle.
- Krdy and Drdy asserted together in IDLE → Kvld pulses, BSY stays 0, no result. Krdy during RUN → the ciphertext still uses the old key.
- RST pulsed at iteration cnt=4 → all outputs 0 next cycle, no Dvld. A fresh block then encrypts correctly with the key reloaded.
- EN low for 3 cycles mid-RUN → latency extends by exactly 3 cycles and the ciphertext is unchanged.

Source files
------------

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared constants, types and GF(2^8) helpers for the unrolled AES-128
// encryption engine.
//   NR            number of AES-128 rounds
//   RCON[1:10]    key-schedule round constants
//   aes_state_e   control FSM states (IDLE -> RUN -> DONE)
//   xtime/gf_mul  GF(2^8) arithmetic, polynomial x^8+x^4+x^3+x+1
//   affine        S-box output affine transform
//   unroll_legal  accepted rounds-per-clock values
//   rcon_of       round constant lookup, 0 outside 1..10
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int NR = 10;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aes_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // b = s ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63
    function automatic logic [7:0] affine(input logic [7:0] s);
        return s ^ {s[6:0], s[7]} ^ {s[5:0], s[7:6]} ^ {s[4:0], s[7:5]}
                 ^ {s[3:0], s[7:4]} ^ 8'h63;
    endfunction

    function automatic bit unroll_legal(input int u);
        return (u == 1) || (u == 2) || (u == 5) || (u == 10);
    endfunction

    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        case (r)
            4'd1:    return RCON[1];
            4'd2:    return RCON[2];
            4'd3:    return RCON[3];
            4'd4:    return RCON[4];
            4'd5:    return RCON[5];
            4'd6:    return RCON[6];
            4'd7:    return RCON[7];
            4'd8:    return RCON[8];
            4'd9:    return RCON[9];
            4'd10:   return RCON[10];
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_round_unit.sv
// ---------------------------------------------------------------------------
// aes_round_unit
// One combinational AES-128 encryption round plus the matching key-schedule
// step. The round key for this round is derived from the previous one and
// used immediately for AddRoundKey.
//   dat_i   state entering the round
//   key_i   previous round key
//   rcon_i  round constant for the key step
//   last_i  final round: MixColumns bypassed
//   dat_o   state after the round
//   key_o   round key of this round
// ---------------------------------------------------------------------------
module aes_round_unit
    import aes_pkg::*;
(
    input  logic [127:0] dat_i,
    input  logic [127:0] key_i,
    input  logic [7:0]   rcon_i,
    input  logic         last_i,
    output logic [127:0] dat_o,
    output logic [127:0] key_o
);

    // Field inverse through the GF(2^4) subfield: n = x^17 is the norm of x
    // and lies in GF(16), so n^-1 = n^14 and x^-1 = x^16 * n^14. Maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x4, x8, x16, n, n2, n4, n8;
        x2  = gf_mul(x, x);
        x4  = gf_mul(x2, x2);
        x8  = gf_mul(x4, x4);
        x16 = gf_mul(x8, x8);
        n   = gf_mul(x16, x);
        n2  = gf_mul(n, n);
        n4  = gf_mul(n2, n2);
        n8  = gf_mul(n4, n4);
        return gf_mul(x16, gf_mul(gf_mul(n8, n4), n2));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return affine(gf_inv(x));
    endfunction

    // Key-schedule step
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;

    always_comb begin
        w0 = key_i[127:96];
        w1 = key_i[95:64];
        w2 = key_i[63:32];
        w3 = key_i[31:0];
        // SubWord(RotWord(w3)) ^ Rcon
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
             ^ {rcon_i, 24'h000000};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        key_o = {n0, n1, n2, n3};
    end

    // Data path. Byte k is dat_i[127-8k -: 8]; bytes are column-major,
    // so byte 4c+r sits in row r of column c.
    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    always_comb begin
        logic [7:0] a0, a1, a2, a3;
        for (int k = 0; k < 16; k++) begin
            sb[k] = sbox(dat_i[127-8*k -: 8]);
        end
        // ShiftRows: row r rotates left by r columns
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c+r] = sb[4*((c+r)%4)+r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c];
            a1 = sr[4*c+1];
            a2 = sr[4*c+2];
            a3 = sr[4*c+3];
            mc[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        for (int k = 0; k < 16; k++) begin
            dat_o[127-8*k -: 8] = (last_i ? sr[k] : mc[k]) ^ key_o[127-8*k -: 8];
        end
    end

endmodule

// File: rtl/aes128_enc_unrolled.sv
// ---------------------------------------------------------------------------
// aes128_enc_unrolled
// AES-128 encryption engine computing UNROLL rounds per enabled clock
// (UNROLL in {1,2,5,10}) with an on-the-fly key schedule, a key register
// that persists across blocks and a hold-until-acknowledged result.
//   CLK, RST     clock, synchronous active-high reset
//   EN           global enable; all state freezes while low
//   Kin, Krdy    key and key-load strobe (accepted in IDLE only)
//   Kvld         one-cycle key-load acknowledge
//   Din, Drdy    plaintext and data-load strobe
//   Dout, Dvld   ciphertext and result valid, held until Dack
//   Dack         result acknowledge; with Drdy loads the next block at once
//   BSY          high in RUN and DONE
//   RKout        round-10 key of the last completed block, present only
//                when AES_RKEY_OUT_EN is defined
//
// Handshake: Krdy/Drdy are single-cycle strobes sampled only where the FSM
// can accept them; Dvld stays high with Dout stable until a cycle where
// Dack is high (and EN is high), which retires the result.
// ---------------------------------------------------------------------------
module aes128_enc_unrolled
    import aes_pkg::*;
#(
    parameter int UNROLL = 1
)
(
    input  logic         CLK,
    input  logic         RST,
    input  logic         EN,
    input  logic [127:0] Kin,
    input  logic         Krdy,
    output logic         Kvld,
    input  logic [127:0] Din,
    input  logic         Drdy,
    output logic [127:0] Dout,
    output logic         Dvld,
    input  logic         Dack,
    output logic         BSY
`ifdef AES_RKEY_OUT_EN
    ,
    output logic [127:0] RKout
`endif
);

    localparam int NITER = NR / UNROLL;

    if (!unroll_legal(UNROLL)) begin : g_bad_unroll
        $error("aes128_enc_unrolled: UNROLL must be 1, 2, 5 or 10");
    end

    aes_state_e   state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] key_q, key_d;
    logic [127:0] dat_q, dat_d;
    logic [127:0] rkey_q, rkey_d;
    logic [127:0] dout_q, dout_d;
    logic         kvld_q, kvld_d;
`ifdef AES_RKEY_OUT_EN
    logic [127:0] rkout_q, rkout_d;
`endif

    // Round-unit chain: stage 0 is the register, stage UNROLL the result
    logic [UNROLL:0][127:0] ch_dat;
    logic [UNROLL:0][127:0] ch_key;

    assign ch_dat[0] = dat_q;
    assign ch_key[0] = rkey_q;

    for (genvar i = 0; i < UNROLL; i++) begin : g_unit
        // Round number handled by this unit in the current iteration
        logic [3:0] rnd;
        assign rnd = 4'(int'(cnt_q) * UNROLL + i + 1);

        aes_round_unit u_round (
            .dat_i  (ch_dat[i]),
            .key_i  (ch_key[i]),
            .rcon_i (rcon_of(rnd)),
            .last_i (rnd == 4'(NR)),
            .dat_o  (ch_dat[i+1]),
            .key_o  (ch_key[i+1])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        dat_d   = dat_q;
        rkey_d  = rkey_q;
        dout_d  = dout_q;
        kvld_d  = 1'b0;
`ifdef AES_RKEY_OUT_EN
        rkout_d = rkout_q;
`endif
        case (state_q)
            IDLE: begin
                // Key load has priority; a simultaneous Drdy is dropped
                if (Krdy) begin
                    key_d  = Kin;
                    kvld_d = 1'b1;
                end else if (Drdy) begin
                    dat_d   = Din ^ key_q;
                    rkey_d  = key_q;
                    cnt_d   = 4'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                dat_d  = ch_dat[UNROLL];
                rkey_d = ch_key[UNROLL];
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'(NITER - 1)) begin
                    state_d = DONE;
                    dout_d  = ch_dat[UNROLL];
`ifdef AES_RKEY_OUT_EN
                    rkout_d = ch_key[UNROLL];
`endif
                end
            end
            DONE: begin
                if (Dack) begin
                    if (Drdy) begin
                        // Back-to-back: the DONE cycle doubles as the load
                        dat_d   = Din ^ key_q;
                        rkey_d  = key_q;
                        cnt_d   = 4'd0;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            key_q   <= '0;
            dat_q   <= '0;
            rkey_q  <= '0;
            dout_q  <= '0;
            kvld_q  <= 1'b0;
`ifdef AES_RKEY_OUT_EN
            rkout_q <= '0;
`endif
        end else if (EN) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            dat_q   <= dat_d;
            rkey_q  <= rkey_d;
            dout_q  <= dout_d;
            kvld_q  <= kvld_d;
`ifdef AES_RKEY_OUT_EN
            rkout_q <= rkout_d;
`endif
        end
    end

    assign Kvld = kvld_q;
    assign Dout = dout_q;
    assign Dvld = (state_q == DONE);
    assign BSY  = (state_q != IDLE);
`ifdef AES_RKEY_OUT_EN
    assign RKout = rkout_q;
`endif

endmodule

// File: tb/tb_aes128_enc_unrolled.sv
module tb_aes128_enc_unrolled;

  localparam logic [127:0] KA  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PA  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CA  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] RKA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KB  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PB  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CB  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] RKB = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, en, dack;
  logic [127:0] kin, din;
  logic         krdy, drdy;
  logic         kvld, dvld, bsy;
  logic [127:0] dout;

  logic [127:0] m_kin, m_din;
  logic         m_krdy, m_drdy;
  logic         kvld2, dvld2, bsy2, kvld5, dvld5, bsy5, kvld10, dvld10, bsy10;
  logic [127:0] dout2, dout5, dout10;
`ifdef AES_RKEY_OUT_EN
  logic [127:0] rkout, rkout2, rkout5, rkout10;
`endif

  aes128_enc_unrolled #(.UNROLL(1)) u1 (
    .CLK(clk), .RST(rst), .EN(en), .Kin(kin), .Krdy(krdy), .Kvld(kvld),
    .Din(din), .Drdy(drdy), .Dout(dout), .Dvld(dvld), .Dack(dack), .BSY(bsy)
`ifdef AES_RKEY_OUT_EN
    , .RKout(rkout)
`endif
  );

  aes128_enc_unrolled #(.UNROLL(2)) u2 (
    .CLK(clk), .RST(rst), .EN(en), .Kin(m_kin), .Krdy(m_krdy), .Kvld(kvld2),
    .Din(m_din), .Drdy(m_drdy), .Dout(dout2), .Dvld(dvld2), .Dack(dack), .BSY(bsy2)
`ifdef AES_RKEY_OUT_EN
    , .RKout(rkout2)
`endif
  );

  aes128_enc_unrolled #(.UNROLL(5)) u5 (
    .CLK(clk), .RST(rst), .EN(en), .Kin(m_kin), .Krdy(m_krdy), .Kvld(kvld5),
    .Din(m_din), .Drdy(m_drdy), .Dout(dout5), .Dvld(dvld5), .Dack(dack), .BSY(bsy5)
`ifdef AES_RKEY_OUT_EN
    , .RKout(rkout5)
`endif
  );

  aes128_enc_unrolled #(.UNROLL(10)) u10 (
    .CLK(clk), .RST(rst), .EN(en), .Kin(m_kin), .Krdy(m_krdy), .Kvld(kvld10),
    .Din(m_din), .Drdy(m_drdy), .Dout(dout10), .Dvld(dvld10), .Dack(dack), .BSY(bsy10)
`ifdef AES_RKEY_OUT_EN
    , .RKout(rkout10)
`endif
  );

  // scoreboard counters
  int n_vec = 0;
  int n_err = 0;
  int lat, lat2, lat5, lat10, hits;
  logic [127:0] c2, c5, c10;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // edges until u1 raises Dvld, -1 if it never does within the budget
  task automatic wait_dvld(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (dvld === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; dack = 1'b1;
    kin = '0; din = '0; krdy = 1'b0; drdy = 1'b0;
    m_kin = '0; m_din = '0; m_krdy = 1'b0; m_drdy = 1'b0;
    step();
    step();
    rst = 1'b0;

    // reset state
    chk("rst_dout", dout, 128'h0);
    chk("rst_dvld", 128'(dvld), 128'h0);
    chk("rst_kvld", 128'(kvld), 128'h0);
    chk("rst_bsy", 128'(bsy), 128'h0);
`ifdef AES_RKEY_OUT_EN
    chk("rst_rkout", rkout, 128'h0);
`endif

    // UNROLL = 2 / 5 / 10 with the FIPS-197 appendix C.1 vector
    m_kin = KB; m_krdy = 1'b1;
    step();
    m_krdy = 1'b0;
    chk("u2_kvld", 128'(kvld2), 128'h1);
    chk("u5_kvld", 128'(kvld5), 128'h1);
    chk("u10_kvld", 128'(kvld10), 128'h1);
    m_din = PB; m_drdy = 1'b1;
    step();
    m_drdy = 1'b0;
    lat2 = -1; lat5 = -1; lat10 = -1;
    c2 = '0; c5 = '0; c10 = '0;
    for (int i = 1; i <= 15; i++) begin
      step();
      if (dvld2 === 1'b1 && lat2 < 0) begin lat2 = i; c2 = dout2; end
      if (dvld5 === 1'b1 && lat5 < 0) begin lat5 = i; c5 = dout5; end
      if (dvld10 === 1'b1 && lat10 < 0) begin lat10 = i; c10 = dout10; end
    end
    chk("u2_lat", 128'(lat2), 128'(5));
    chk("u5_lat", 128'(lat5), 128'(2));
    chk("u10_lat", 128'(lat10), 128'(1));
    chk("u2_ct", c2, CB);
    chk("u5_ct", c5, CB);
    chk("u10_ct", c10, CB);
    chk("u2_bsy_end", 128'(bsy2), 128'h0);
    chk("u5_bsy_end", 128'(bsy5), 128'h0);
    chk("u10_bsy_end", 128'(bsy10), 128'h0);
`ifdef AES_RKEY_OUT_EN
    chk("u2_rkout", rkout2, RKB);
    chk("u5_rkout", rkout5, RKB);
    chk("u10_rkout", rkout10, RKB);
`endif

    // UNROLL = 1: key load pulse
    kin = KA; krdy = 1'b1;
    step();
    krdy = 1'b0;
    chk("kvld_rise", 128'(kvld), 128'h1);
    step();
    chk("kvld_fall", 128'(kvld), 128'h0);

    // FIPS-197 appendix B block, Dack high
    din = PA; drdy = 1'b1;
    step();
    drdy = 1'b0;
    chk("bsy_rise", 128'(bsy), 128'h1);
    wait_dvld(lat);
    chk("a_lat", 128'(lat), 128'(10));
    chk("a_ct", dout, CA);
`ifdef AES_RKEY_OUT_EN
    chk("a_rkout", rkout, RKA);
`endif
    step();
    chk("a_dvld_fall", 128'(dvld), 128'h0);
    chk("a_bsy_fall", 128'(bsy), 128'h0);
    chk("a_dout_keep", dout, CA);

    // hold with Dack low, ignored Drdy pulse, then back-to-back
    kin = KB; krdy = 1'b1;
    step();
    krdy = 1'b0;
    dack = 1'b0;
    din = PB; drdy = 1'b1;
    step();
    drdy = 1'b0;
    wait_dvld(lat);
    chk("b_lat", 128'(lat), 128'(10));
    chk("b_ct", dout, CB);
    for (int i = 0; i < 7; i++) begin
      if (i == 3) begin din = PA; drdy = 1'b1; end
      step();
      drdy = 1'b0;
      chk("hold_dvld", 128'(dvld), 128'h1);
      chk("hold_dout", dout, CB);
    end
    dack = 1'b1; din = PB; drdy = 1'b1;
    step();
    dack = 1'b0; drdy = 1'b0;
    chk("b2b_dvld", 128'(dvld), 128'h0);
    chk("b2b_bsy", 128'(bsy), 128'h1);
    wait_dvld(lat);
    chk("b2b_lat", 128'(lat), 128'(10));
    chk("b2b_ct", dout, CB);
    dack = 1'b1;
    step();
    chk("b2b_idle", 128'(bsy), 128'h0);

    // Krdy and Drdy together in IDLE: key wins, block dropped
    kin = KA; din = PB; krdy = 1'b1; drdy = 1'b1;
    step();
    krdy = 1'b0; drdy = 1'b0;
    chk("kd_kvld", 128'(kvld), 128'h1);
    chk("kd_bsy", 128'(bsy), 128'h0);
    step();
    chk("kd_bsy2", 128'(bsy), 128'h0);
    chk("kd_dvld", 128'(dvld), 128'h0);

    // Krdy during RUN is ignored: old key (KA) still used
    din = PA; drdy = 1'b1;
    step();
    drdy = 1'b0;
    step();
    kin = KB; krdy = 1'b1;
    step();
    krdy = 1'b0;
    chk("run_kvld", 128'(kvld), 128'h0);
    wait_dvld(lat);
    chk("run_lat", 128'(lat + 2), 128'(10));
    chk("run_ct", dout, CA);
    step();

    // reset at cnt = 4 aborts the block
    din = PA; drdy = 1'b1;
    step();
    drdy = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_dout", dout, 128'h0);
    chk("mid_rst_dvld", 128'(dvld), 128'h0);
    chk("mid_rst_bsy", 128'(bsy), 128'h0);
    chk("mid_rst_kvld", 128'(kvld), 128'h0);
`ifdef AES_RKEY_OUT_EN
    chk("mid_rst_rkout", rkout, 128'h0);
`endif
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (dvld !== 1'b0) hits++;
    end
    chk("no_dvld_after_rst", 128'(hits), 128'h0);
    kin = KB; krdy = 1'b1;
    step();
    krdy = 1'b0;
    din = PB; drdy = 1'b1;
    step();
    drdy = 1'b0;
    wait_dvld(lat);
    chk("post_rst_lat", 128'(lat), 128'(10));
    chk("post_rst_ct", dout, CB);
    step();

    // EN low for 3 cycles mid-RUN stretches latency by 3
    din = PB; drdy = 1'b1;
    step();
    drdy = 1'b0;
    for (int i = 0; i < 3; i++) step();
    en = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("en_freeze_bsy", 128'(bsy), 128'h1);
    chk("en_freeze_dvld", 128'(dvld), 128'h0);
    en = 1'b1;
    wait_dvld(lat);
    chk("en_lat", 128'(lat + 6), 128'(13));
    chk("en_ct", dout, CB);
`ifdef AES_RKEY_OUT_EN
    chk("en_rkout", rkout, RKB);
`endif
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
